async_fifo_wr_side: RTL

Write-domain half of the clk2→clk1 result FIFO. It sits directly downstream of the convolution engine in the clk2 domain. It accepts 8-bit conv results with a valid strobe, drives the dual-port FIFO memory write port, and keeps the binary and Gray write pointers. It also synchronises the read-domain Gray pointer, generates a registered pessimistic full flag that backpressures the engine, and counts results per 150-word frame.

---
 rtl/async_fifo_wr_side.sv | 117 +++++++++++
 1 files changed

// File: rtl/async_fifo_wr_side.sv
// Write-domain half of the clk2->clk1 result FIFO.
// Accepts conv-engine results, drives the FIFO memory write port, keeps the
// binary/Gray write pointers, synchronises the read pointer, raises a
// pessimistic registered full flag and counts accepted words per frame.
module async_fifo_wr_side #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FRAME_LEN = 150
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic              wfull,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wcount,
  output logic              frame_done,
  output logic              overflow_err
);

  localparam int unsigned PW         = ADDR_W + 1;
  localparam logic [7:0]  FRAME_LAST = 8'(FRAME_LEN - 1);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] rq1;
  logic [ADDR_W:0] rq2;
  logic [ADDR_W:0] rq2_bin;
  logic [ADDR_W:0] full_gray;
  logic            accept;
  logic [7:0]      fcnt;

  // Accept decision, next pointer values and the full-compare target.
  // Full means the next write pointer equals the synchronised read pointer
  // plus 2^ADDR_W, which in Gray code is the top two bits inverted.
  always_comb begin
    accept     = winc & ~wfull;
    wbin_next  = wbin + {{ADDR_W{1'b0}}, accept};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_gray  = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
  end

  // Gray-to-binary of the synchronised read pointer: bit i is the XOR of
  // all Gray bits at or above i.
  always_comb begin
    rq2_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rq2_bin[i] = ^(rq2 >> i);
    end
  end

  // Memory write port and write-side occupancy.
  always_comb begin
    mem_we    = accept;
    mem_waddr = wbin[ADDR_W-1:0];
    mem_wdata = wdata;
    wcount    = wbin - rq2_bin;
  end

  // Two-flop synchroniser for the read-domain Gray pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
    end
  end

  // Write pointers and full flag; full uses the pre-edge rq2 so it can only
  // be pessimistic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      wfull     <= (wgray_next == full_gray);
    end
  end

  // Per-frame accepted-word counter with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (fcnt == FRAME_LAST) begin
          fcnt       <= '0;
          frame_done <= 1'b1;
        end else begin
          fcnt <= fcnt + 8'd1;
        end
      end
    end
  end

  // Sticky error for writes attempted while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (winc && wfull) begin
      overflow_err <= 1'b1;
    end
  end

endmodule
